// File: rtl/idiv_rem_fu.sv
// Iterative integer divide/remainder unit.
// One restoring shift-subtract step per clock on operand magnitudes, with a
// sign fix when results load. Divide-by-zero and signed overflow complete
// straight from IDLE without entering BUSY.
module idiv_rem_fu #(
  parameter int RSZ = 32
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           start,
  input  logic [RSZ-1:0] Rs1_data,
  input  logic [RSZ-1:0] Rs2_data,
  input  logic [1:0]     op,
  output logic [RSZ-1:0] quotient,
  output logic [RSZ-1:0] remainder,
  output logic           done
);

  // op encoding: bit 0 set selects unsigned, bit 1 set selects REM.
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [RSZ-1:0] MIN_NEG = {1'b1, {(RSZ-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [5:0]     cnt;
  logic [RSZ-1:0] dvd_q;   // dividend magnitude, quotient bits shift in at the bottom
  logic [RSZ-1:0] dvs;     // divisor magnitude
  logic [RSZ-1:0] prem;    // partial remainder (always below the divisor)
  logic           neg_q;
  logic           neg_r;

  logic signed [RSZ-1:0] dividend_s;
  logic signed [RSZ-1:0] divisor_s;
  logic                  is_signed;
  logic                  dvd_neg;
  logic                  dvs_neg;
  logic                  div_zero;
  logic                  overflow;

  logic [RSZ:0]   shift;
  logic [RSZ:0]   diff;
  logic           qbit;
  logic [RSZ-1:0] prem_nxt;
  logic [RSZ-1:0] quo_nxt;

  // Magnitude of a possibly-negative operand; the most negative value maps
  // to itself, which is its correct unsigned magnitude.
  function automatic logic [RSZ-1:0] magnitude(input logic [RSZ-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Restore the sign of a magnitude result.
  function automatic logic [RSZ-1:0] apply_sign(input logic [RSZ-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign dividend_s = Rs1_data;
  assign divisor_s  = Rs2_data;
  assign is_signed  = (op == OP_DIV) || (op == OP_REM);
  assign dvd_neg    = is_signed && (dividend_s < 0);
  assign dvs_neg    = is_signed && (divisor_s < 0);
  assign div_zero   = (Rs2_data == '0);
  assign overflow   = is_signed && (Rs1_data == MIN_NEG) && (Rs2_data == '1);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shift    = {prem, dvd_q[RSZ-1]};
    diff     = shift - {1'b0, dvs};
    qbit     = ~diff[RSZ];
    prem_nxt = qbit ? diff[RSZ-1:0] : shift[RSZ-1:0];
    quo_nxt  = {dvd_q[RSZ-2:0], qbit};
  end

  // Control FSM with registered results and completion pulse.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (div_zero) begin
              quotient  <= '1;
              remainder <= Rs1_data;
              done      <= 1'b1;
              state     <= DONE;
            end else if (overflow) begin
              quotient  <= MIN_NEG;
              remainder <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              dvd_q <= magnitude(Rs1_data, dvd_neg);
              dvs   <= magnitude(Rs2_data, dvs_neg);
              prem  <= '0;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd_q <= quo_nxt;
          prem  <= prem_nxt;
          cnt   <= cnt + 6'd1;
          if (cnt == 6'(RSZ-1)) begin
            quotient  <= apply_sign(quo_nxt, neg_q);
            remainder <= apply_sign(prem_nxt, neg_r);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idiv_rem_fu.sv
// Self-checking bench for idiv_rem_fu: expected results go into a scoreboard
// queue when an operation is issued and are popped when done is seen.
// Latency is counted in clock edges after the accept edge at which done
// becomes registered high (0 for the bypass cases, 32 for a normal divide).
module tb_idiv_rem_fu;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start;
  logic [31:0] Rs1_data;
  logic [31:0] Rs2_data;
  logic [1:0]  op;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  exp_t sb[$];

  idiv_rem_fu #(.RSZ(32)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .start     (start),
    .Rs1_data  (Rs1_data),
    .Rs2_data  (Rs2_data),
    .op        (op),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  // Reference behaviour built on the simulator's own division operators.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    exp_t   e;
    longint sa;
    longint sb_v;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 0;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 0;
    end else if (!o[0]) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.q = 32'(sa / sb_v); e.r = 32'(sa % sb_v); e.lat = 32;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = 32;
    end
    return e;
  endfunction

  // Issue one operation and report what the DUT produced.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output logic one_cycle);
    @(negedge clk_in);
    Rs1_data = a; Rs2_data = b; op = o; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk_in); #1;
      lat++;
    end
    q = quotient; r = remainder;
    @(posedge clk_in); #1;
    one_cycle = (done === 1'b0);
  endtask

  task automatic test_reset();
    reset_in = 1'b0; start = 1'b1; Rs1_data = 32'd5; Rs2_data = 32'd0; op = DIV;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 32'd0) $display("FAIL reset_quotient got %h want 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'd0) $display("FAIL reset_remainder got %h want 0", remainder); else n_pass++;
    @(negedge clk_in);
    start = 1'b0; reset_in = 1'b1;
  endtask

  task automatic test_spec_vectors();
    vec_t        v[10];
    exp_t        e;
    logic [31:0] q, r;
    int          lat;
    logic        one;
    v[0] = '{32'd100,       32'd7,         DIVU, 32'd14,        32'd2,         32};
    v[1] = '{32'hFFFF_FFF9, 32'd2,         DIV,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32};
    v[2] = '{32'hFFFF_FFF9, 32'd2,         REM,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32};
    v[3] = '{32'hFFFF_FFFF, 32'h10,        REMU, 32'h0FFF_FFFF, 32'hF,         32};
    v[4] = '{32'd5,         32'd0,         DIV,  32'hFFFF_FFFF, 32'd5,         0};
    v[5] = '{32'h8000_0000, 32'd0,         DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    v[6] = '{32'h8000_0000, 32'hFFFF_FFFF, DIV,  32'h8000_0000, 32'd0,         0};
    v[7] = '{32'h8000_0000, 32'hFFFF_FFFF, REM,  32'h8000_0000, 32'd0,         0};
    v[8] = '{32'h8000_0000, 32'hFFFF_FFFF, DIVU, 32'd0,         32'h8000_0000, 32};
    v[9] = '{32'd7,         32'hFFFF_FFFE, DIV,  32'hFFFF_FFFD, 32'd1,         32};
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{v[i].q, v[i].r, v[i].lat});
      run_op(v[i].a, v[i].b, v[i].o, q, r, lat, one);
      e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL vec%0d_quotient got %h want %h", i, q, e.q); else n_pass++;
      n_checks++; if (r !== e.r) $display("FAIL vec%0d_remainder got %h want %h", i, r, e.r); else n_pass++;
      n_checks++; if (lat !== e.lat) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, e.lat); else n_pass++;
      n_checks++; if (one !== 1'b1) $display("FAIL vec%0d_done_width got multi-cycle want one cycle", i); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic [1:0]  o;
    int          lat;
    logic        one;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 4 == 1) b = -b;
      o = 2'(i % 4);
      sb.push_back(model(a, b, o));
      run_op(a, b, o, q, r, lat, one);
      e = sb.pop_front();
      n_checks++; if (q !== e.q) $display("FAIL rand%0d_quotient got %h want %h", i, q, e.q); else n_pass++;
      n_checks++; if (r !== e.r) $display("FAIL rand%0d_remainder got %h want %h", i, r, e.r); else n_pass++;
      n_checks++; if (lat !== e.lat) $display("FAIL rand%0d_latency got %0d want %0d", i, lat, e.lat); else n_pass++;
    end
  endtask

  // Start pulses and operand changes during BUSY and DONE must be ignored.
  task automatic test_start_during_busy();
    int   n_done = 0;
    int   done_edge = -1;
    exp_t e;
    sb.push_back('{32'd14, 32'd2, 32});
    @(negedge clk_in);
    Rs1_data = 32'd100; Rs2_data = 32'd7; op = DIVU; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk_in); #1;
      if (done === 1'b1) begin n_done++; if (done_edge < 0) done_edge = k; end
      if (k == 6)  begin Rs1_data = 32'd1000; Rs2_data = 32'd3; op = DIV; start = 1'b1; end
      if (k == 8)  start = 1'b0;
      if (k == 32) start = 1'b1;
      if (k == 33) start = 1'b0;
    end
    e = sb.pop_front();
    n_checks++; if (n_done !== 1) $display("FAIL busy_start_done_count got %0d want 1", n_done); else n_pass++;
    n_checks++; if (done_edge !== e.lat) $display("FAIL busy_start_latency got %0d want %0d", done_edge, e.lat); else n_pass++;
    n_checks++; if (quotient !== e.q) $display("FAIL busy_start_quotient got %h want %h", quotient, e.q); else n_pass++;
    n_checks++; if (remainder !== e.r) $display("FAIL busy_start_remainder got %h want %h", remainder, e.r); else n_pass++;
  endtask

  // Holding start high gives one completion every 34 clocks.
  task automatic test_back_to_back();
    int edges[$];
    int want;
    @(negedge clk_in);
    Rs1_data = 32'd100; Rs2_data = 32'd7; op = DIVU; start = 1'b1;
    for (int k = 0; k <= 110; k++) begin
      @(posedge clk_in); #1;
      if (done === 1'b1) begin
        edges.push_back(k);
        n_checks++; if (quotient !== 32'd14) $display("FAIL b2b_quotient got %h want 0000000e", quotient); else n_pass++;
      end
    end
    start = 1'b0;
    repeat (40) @(posedge clk_in);
    #1;
    n_checks++; if (edges.size() !== 3) $display("FAIL b2b_done_count got %0d want 3", edges.size()); else n_pass++;
    for (int i = 0; i < edges.size() && i < 3; i++) begin
      want = 32 + 34 * i;
      n_checks++; if (edges[i] !== want) $display("FAIL b2b_done_edge%0d got %0d want %0d", i, edges[i], want); else n_pass++;
    end
  endtask

  // Reset during BUSY aborts silently; the next operation runs normally.
  task automatic test_reset_mid_busy();
    int          n_done = 0;
    logic [31:0] q, r;
    int          lat;
    logic        one;
    exp_t        e;
    @(negedge clk_in);
    Rs1_data = 32'd1000; Rs2_data = 32'd3; op = DIVU; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (9) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    @(posedge clk_in); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else n_pass++;
    n_checks++; if (quotient !== 32'd0) $display("FAIL midrst_quotient got %h want 0", quotient); else n_pass++;
    n_checks++; if (remainder !== 32'd0) $display("FAIL midrst_remainder got %h want 0", remainder); else n_pass++;
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_in); #1;
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL midrst_no_done got %0d pulses want 0", n_done); else n_pass++;
    sb.push_back('{32'd3, 32'd0, 32});
    run_op(32'd9, 32'd3, DIVU, q, r, lat, one);
    e = sb.pop_front();
    n_checks++; if (q !== e.q) $display("FAIL after_rst_quotient got %h want %h", q, e.q); else n_pass++;
    n_checks++; if (r !== e.r) $display("FAIL after_rst_remainder got %h want %h", r, e.r); else n_pass++;
    n_checks++; if (lat !== e.lat) $display("FAIL after_rst_latency got %0d want %0d", lat, e.lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d of %0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule
